truth_table_sweeper: RTL and testbench

- Parametrised successor to the fixed 3-input combinational function block.
- Holds an N-input Boolean function as a writable 2^N-bit truth table.
- Evaluates the function registered, one cycle after the inputs are applied.
- Has a self-timed sweep mode. It steps the input vector 0..2^N-1, emits index/value pairs with a valid strobe, counts minterms where f=1, and pulses done.
- Sits beside lab logic as a reusable, self-checking function generator.

---
 rtl/truth_table_sweeper_pkg.sv | 21 ++
 rtl/truth_table_sweeper_if.sv | 36 +++
 rtl/truth_table_sweeper_step.sv | 44 ++++
 rtl/truth_table_sweeper.sv | 153 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_pkg: shared definitions for the truth-table sweeper.
//   sweep_state_t : sweep controller states (IDLE, RUN, DONE)
//   depth()       : table depth 2^n for an n-input function
//   step_width()  : counter width able to hold 0..step-1, never below 1 bit
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  function automatic int depth(input int n);
    return 1 << n;
  endfunction

  function automatic int step_width(input int step);
    return (step <= 1) ? 1 : $clog2(step);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: the sweeper's eval, table-write and sweep signals.
//   in_vec, f                    : eval input vector and registered result
//   tt_we, tt_addr, tt_din       : single truth-table bit write
//   start, abort                 : sweep control
//   busy, out_valid, out_idx,
//   out_f, ones_count, done      : sweep status and sample stream
// master drives the requests (lab logic / bench), slave is the sweeper.
interface truth_table_sweeper_if #(
  parameter int N = 3
) ();

  logic [N-1:0] in_vec;
  logic         f;
  logic         tt_we;
  logic [N-1:0] tt_addr;
  logic         tt_din;
  logic         start;
  logic         abort;
  logic         busy;
  logic         out_valid;
  logic [N-1:0] out_idx;
  logic         out_f;
  logic [N:0]   ones_count;
  logic         done;

  modport master (
    output in_vec, tt_we, tt_addr, tt_din, start, abort,
    input  f, busy, out_valid, out_idx, out_f, ones_count, done
  );

  modport slave (
    input  in_vec, tt_we, tt_addr, tt_din, start, abort,
    output f, busy, out_valid, out_idx, out_f, ones_count, done
  );

endinterface

// File: rtl/truth_table_sweeper_step.sv
// sweep_step_timer: counts the STEP cycles spent on one sweep index.
//   clk, rst : clock, async active-high reset
//   clear    : force the count back to 0 (sweep start)
//   enable   : advance the count, wrapping from STEP-1 to 0
//   first    : count == 0 (sample cycle of the current index)
//   last     : count == STEP-1 (final cycle of the current index)
module sweep_step_timer
  import truth_table_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic first,
  output logic last
);

  localparam int W = step_width(STEP);
  localparam logic [W-1:0] LAST_COUNT = W'(STEP - 1);

  logic [W-1:0] count;

  // The counter wraps on its own at STEP-1 so the controller only has to
  // look at first/last and never does any modulo arithmetic itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST_COUNT) begin
        count <= '0;
      end else begin
        count <= count + W'(1);
      end
    end
  end

  assign first = (count == '0);
  assign last  = (count == LAST_COUNT);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: N-input Boolean function held as a writable truth table,
// with a registered eval path and a self-timed sweep of every input vector.
//   clk, rst : clock, async active-high reset (table reloads TT_INIT)
//   bus      : truth_table_sweeper_if slave
//              eval  : in_vec -> f, one cycle latency, in every state
//              write : tt_we/tt_addr/tt_din, honoured only in IDLE
//              sweep : start/abort in; busy, out_valid, out_idx, out_f,
//                      ones_count, done out
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int                      N       = 3,
  parameter int                      STEP    = 1,
  parameter logic [depth(N)-1:0]     TT_INIT = 8'hBD
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus
);

  localparam int DEPTH = depth(N);
  localparam logic [N-1:0] IDX_LAST = N'(DEPTH - 1);

  sweep_state_t      state;
  sweep_state_t      state_next;
  logic [DEPTH-1:0]  tt;
  logic [DEPTH-1:0]  tt_next;
  logic [N-1:0]      idx;
  logic [N:0]        ones_count_r;
  logic              out_f_r;
  logic              f_r;

  logic              step_first;
  logic              step_last;
  logic              timer_clear;
  logic              sweep_start;
  logic              sweep_advance;
  logic              sample_commit;

  sweep_step_timer #(
    .STEP (STEP)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (state == RUN),
    .first  (step_first),
    .last   (step_last)
  );

  // Table write path. Writes are only honoured in IDLE; building the
  // post-write table combinationally lets a start in the same cycle load
  // the first sample from the freshly written table.
  always_comb begin
    tt_next = tt;
    if ((state == IDLE) && bus.tt_we) begin
      tt_next[bus.tt_addr] = bus.tt_din;
    end
  end

  // Sweep controller next-state logic. An abort cuts the current index
  // short, so its sample is not added to ones_count; start takes priority
  // over abort in IDLE simply because IDLE never looks at abort.
  always_comb begin
    state_next    = state;
    timer_clear   = 1'b0;
    sweep_start   = 1'b0;
    sweep_advance = 1'b0;
    sample_commit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next  = RUN;
          timer_clear = 1'b1;
          sweep_start = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else begin
          sample_commit = step_first;
          if (step_last) begin
            if (idx == IDX_LAST) begin
              state_next = DONE;
            end else begin
              sweep_advance = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Truth table storage and the registered eval result. The eval path
  // runs regardless of the sweep so lab logic always sees f one cycle on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt  <= TT_INIT;
      f_r <= 1'b0;
    end else begin
      tt  <= tt_next;
      f_r <= tt[bus.in_vec];
    end
  end

  // Sweep datapath. out_f is preloaded with the value of the index about to
  // be presented, so out_idx/out_f come straight from registers and simply
  // hold once the sweep leaves RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      ones_count_r <= '0;
      out_f_r      <= 1'b0;
    end else if (sweep_start) begin
      idx          <= '0;
      ones_count_r <= '0;
      out_f_r      <= tt_next[0];
    end else begin
      if (sample_commit) begin
        ones_count_r <= ones_count_r + (N+1)'(out_f_r);
      end
      if (sweep_advance) begin
        idx     <= idx + N'(1);
        out_f_r <= tt[idx + N'(1)];
      end
    end
  end

  assign bus.f          = f_r;
  assign bus.busy       = (state != IDLE);
  assign bus.out_valid  = (state == RUN) && step_first;
  assign bus.out_idx    = idx;
  assign bus.out_f      = out_f_r;
  assign bus.ones_count = ones_count_r;
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: self-checking bench for truth_table_sweeper.
// Two instances: A (N=3, STEP=1, 8'hBD) and B (N=2, STEP=3, 4'hF).
// Expected sweep samples are queued when a sweep is started and popped by a
// per-instance monitor on every out_valid.
module tb_truth_table_sweeper;

  typedef struct {
    logic [7:0] idx;
    logic       f;
  } exp_t;

  logic clk;
  logic rst;

  int compare_count;
  int mismatch_count;

  exp_t qa[$];
  exp_t qb[$];
  int   a_valid_seen;
  int   a_done_seen;
  logic [7:0] tt_model;

  truth_table_sweeper_if #(.N(3)) a_if ();
  truth_table_sweeper_if #(.N(2)) b_if ();

  truth_table_sweeper #(
    .N       (3),
    .STEP    (1),
    .TT_INIT (8'hBD)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  truth_table_sweeper #(
    .N       (2),
    .STEP    (3),
    .TT_INIT (4'hF)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the flow itself wedges.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected summary before 100000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of A's request strobes, then drop them again.
  task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic din,
                               input logic st, input logic ab);
    a_if.tt_we   = we;
    a_if.tt_addr = addr;
    a_if.tt_din  = din;
    a_if.start   = st;
    a_if.abort   = ab;
    tick();
    a_if.tt_we   = 1'b0;
    a_if.start   = 1'b0;
    a_if.abort   = 1'b0;
  endtask

  task automatic pushSweepA(input int last_idx);
    exp_t e;
    for (int i = 0; i <= last_idx; i++) begin
      e.idx = 8'(i);
      e.f   = tt_model[i];
      qa.push_back(e);
    end
  endtask

  // Waits (bounded) for A's done; cycles counts from the cycle after start.
  task automatic waitDoneA(output int cycles);
    cycles = 1;
    while (a_if.done !== 1'b1 && cycles < 60) begin
      tick();
      cycles++;
    end
    if (a_if.done !== 1'b1) begin
      checkOutput("a_done_timeout", 32'(a_if.done), 32'd1);
    end
  endtask

  // Scoreboard monitor for A: every valid sample must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (a_if.out_valid === 1'b1) begin
      a_valid_seen++;
      if (qa.size() == 0) begin
        checkOutput("a_extra_valid", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        checkOutput("a_out_idx", 32'(a_if.out_idx), 32'(e.idx));
        checkOutput("a_out_f", 32'(a_if.out_f), 32'(e.f));
      end
    end
    if (a_if.done === 1'b1) begin
      a_done_seen++;
    end
  end

  // Scoreboard monitor for B.
  always @(negedge clk) begin
    exp_t e;
    if (b_if.out_valid === 1'b1) begin
      if (qb.size() == 0) begin
        checkOutput("b_extra_valid", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        checkOutput("b_out_idx", 32'(b_if.out_idx), 32'(e.idx));
        checkOutput("b_out_f", 32'(b_if.out_f), 32'(e.f));
      end
    end
  end

  initial begin
    int   cycles;
    int   c;
    int   pulses;
    int   bad_pos;
    int   done_at;
    logic [2:0] ones_b;
    exp_t e;

    compare_count  = 0;
    mismatch_count = 0;
    a_valid_seen   = 0;
    a_done_seen    = 0;
    tt_model       = 8'hBD;

    rst          = 1'b1;
    a_if.in_vec  = '0;
    a_if.tt_we   = 1'b0;
    a_if.tt_addr = '0;
    a_if.tt_din  = 1'b0;
    a_if.start   = 1'b0;
    a_if.abort   = 1'b0;
    b_if.in_vec  = '0;
    b_if.tt_we   = 1'b0;
    b_if.tt_addr = '0;
    b_if.tt_din  = 1'b0;
    b_if.start   = 1'b0;
    b_if.abort   = 1'b0;

    // Reset values.
    tick();
    tick();
    checkOutput("rst_f", 32'(a_if.f), 32'd0);
    checkOutput("rst_busy", 32'(a_if.busy), 32'd0);
    checkOutput("rst_valid", 32'(a_if.out_valid), 32'd0);
    checkOutput("rst_done", 32'(a_if.done), 32'd0);
    checkOutput("rst_out_idx", 32'(a_if.out_idx), 32'd0);
    checkOutput("rst_ones", 32'(a_if.ones_count), 32'd0);
    rst = 1'b0;
    tick();

    // Eval: f follows tt[in_vec] one cycle late.
    $display("[TB] eval sweep of in_vec");
    for (int v = 0; v < 8; v++) begin
      a_if.in_vec = 3'(v);
      if (v > 0) checkOutput("eval_late", 32'(a_if.f), 32'(tt_model[v-1]));
      tick();
      checkOutput("eval", 32'(a_if.f), 32'(tt_model[v]));
    end

    // Default sweep.
    $display("[TB] default sweep");
    checkOutput("idle_busy", 32'(a_if.busy), 32'd0);
    a_valid_seen = 0;
    a_done_seen  = 0;
    pushSweepA(7);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("busy_rise", 32'(a_if.busy), 32'd1);
    waitDoneA(cycles);
    checkOutput("done_cycle", 32'(cycles), 32'd9);
    checkOutput("ones_default", 32'(a_if.ones_count), 32'd6);
    checkOutput("valid_pulses", 32'(a_valid_seen), 32'd8);
    checkOutput("queue_drained", 32'(qa.size()), 32'd0);
    tick();
    checkOutput("after_done_busy", 32'(a_if.busy), 32'd0);
    checkOutput("after_done_done", 32'(a_if.done), 32'd0);
    checkOutput("ones_hold", 32'(a_if.ones_count), 32'd6);

    // Write in the start cycle, then a write during RUN that must be ignored.
    $display("[TB] write with start, write during run");
    tt_model[6] = 1'b1;
    pushSweepA(7);
    applyStimulus(1'b1, 3'd6, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    waitDoneA(cycles);
    checkOutput("ones_written", 32'(a_if.ones_count), 32'd7);
    tick();

    // Second sweep shows idx 0 still 1; start mid-RUN must not restart.
    $display("[TB] start while busy");
    a_done_seen = 0;
    pushSweepA(7);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    waitDoneA(cycles);
    checkOutput("ones_no_restart", 32'(a_if.ones_count), 32'd7);
    for (int i = 0; i < 12; i++) tick();
    checkOutput("single_done", 32'(a_done_seen), 32'd1);
    checkOutput("no_restart_queue", 32'(qa.size()), 32'd0);
    checkOutput("no_restart_busy", 32'(a_if.busy), 32'd0);

    // Abort after idx 2; the abort coincides with idx 3 and drops it.
    $display("[TB] abort");
    a_done_seen = 0;
    pushSweepA(3);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_busy", 32'(a_if.busy), 32'd0);
    checkOutput("abort_valid", 32'(a_if.out_valid), 32'd0);
    checkOutput("abort_ones", 32'(a_if.ones_count), 32'd2);
    checkOutput("abort_idx_hold", 32'(a_if.out_idx), 32'd3);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("abort_no_done", 32'(a_done_seen), 32'd0);
    checkOutput("abort_ones_hold", 32'(a_if.ones_count), 32'd2);
    checkOutput("abort_queue", 32'(qa.size()), 32'd0);

    // Start and abort together in IDLE: start wins.
    $display("[TB] start with abort in idle");
    pushSweepA(7);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("start_wins_busy", 32'(a_if.busy), 32'd1);
    waitDoneA(cycles);
    checkOutput("start_wins_ones", 32'(a_if.ones_count), 32'd7);
    tick();

    // STEP=3, N=2, all-ones table on instance B.
    $display("[TB] slow sweep on B");
    for (int i = 0; i < 4; i++) begin
      e.idx = 8'(i);
      e.f   = 1'b1;
      qb.push_back(e);
    end
    b_if.start = 1'b1;
    tick();
    b_if.start = 1'b0;
    c       = 0;
    pulses  = 0;
    bad_pos = 0;
    done_at = -1;
    ones_b  = '0;
    while (b_if.busy === 1'b1 && c < 60) begin
      if (b_if.out_valid === 1'b1) begin
        pulses++;
        if ((c % 3) != 0 || c >= 12) bad_pos++;
      end
      if (b_if.done === 1'b1) begin
        done_at = c;
        ones_b  = b_if.ones_count;
      end
      c++;
      tick();
    end
    checkOutput("b_busy_cycles", 32'(c), 32'd13);
    checkOutput("b_pulses", 32'(pulses), 32'd4);
    checkOutput("b_pulse_pos", 32'(bad_pos), 32'd0);
    checkOutput("b_done_at", 32'(done_at), 32'd12);
    checkOutput("b_ones", 32'(ones_b), 32'd4);
    checkOutput("b_queue", 32'(qb.size()), 32'd0);

    // Reset mid-sweep after a table write.
    $display("[TB] reset mid-sweep");
    tt_model[1] = 1'b1;
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    pushSweepA(4);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("pre_rst_idx", 32'(a_if.out_idx), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_f", 32'(a_if.f), 32'd0);
    checkOutput("arst_busy", 32'(a_if.busy), 32'd0);
    checkOutput("arst_valid", 32'(a_if.out_valid), 32'd0);
    checkOutput("arst_idx", 32'(a_if.out_idx), 32'd0);
    checkOutput("arst_out_f", 32'(a_if.out_f), 32'd0);
    checkOutput("arst_ones", 32'(a_if.ones_count), 32'd0);
    qa.delete();
    tick();
    rst = 1'b0;
    tick();
    tt_model = 8'hBD;
    pushSweepA(7);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    waitDoneA(cycles);
    checkOutput("post_rst_ones", 32'(a_if.ones_count), 32'd6);
    tick();
    checkOutput("post_rst_queue", 32'(qa.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
